axi_lite_wr_arbiter: RTL and testbench
======================================

Name: axi_lite_wr_arbiter

Overview:
- Round-robin write-channel arbiter that shares one AXI-Lite slave port between NoMst AXI-Lite masters.
- Covers the AW, W and B channels and sits in front of the AXI-Lite to AXI converter on the configuration bus.
- Allows one write transaction in flight at a time and returns each B to the master that issued the write.
- The read path is out of scope and is handled by a sibling block.

Parameters:
- NoMst, 4, number of requesting masters; must be at least 2.
- AddrWidth, 32, AW address width.
- DataWidth, 32, W data width; strobe width is DataWidth/8.
- IdxWidth, $clog2(NoMst), width of the grant index; derived, do not override.

Ports:
- clk_i  in  1  clock; all logic is on the rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- slv_aw_valid_i  in  NoMst  AW valid, one bit per master.
- slv_aw_addr_i  in  NoMst*AddrWidth  AW address; master k occupies slice k.
- slv_aw_ready_o  out  NoMst  AW ready, one bit per master.
- slv_w_valid_i  in  NoMst  W valid, one bit per master.
- slv_w_data_i  in  NoMst*DataWidth  W data, sliced per master.
- slv_w_strb_i  in  NoMst*DataWidth/8  W strobe, sliced per master.
- slv_w_ready_o  out  NoMst  W ready, one bit per master.
- slv_b_valid_o  out  NoMst  B valid, one bit per master.
- slv_b_resp_o  out  NoMst*2  B response; every slice carries the downstream resp.
- slv_b_ready_i  in  NoMst  B ready, one bit per master.
- mst_aw_valid_o  out  1  downstream AW valid.
- mst_aw_addr_o  out  AddrWidth  downstream AW address.
- mst_aw_ready_i  in  1  downstream AW ready.
- mst_w_valid_o  out  1  downstream W valid.
- mst_w_data_o  out  DataWidth  downstream W data.
- mst_w_strb_o  out  DataWidth/8  downstream W strobe.
- mst_w_ready_i  in  1  downstream W ready.
- mst_b_valid_i  in  1  downstream B valid.
- mst_b_resp_i  in  2  downstream B response.
- mst_b_ready_o  out  1  downstream B ready.

Behaviour:
- Registers: state_q (IDLE, XFER, RESP), idx_q (current grant), ptr_q (round-robin start point), aw_done_q, w_done_q.
- Reset: state_q=IDLE, ptr_q=0, idx_q=0, done flags=0. Every valid and ready output is 0 during and immediately after reset.
- Reset mid-transaction aborts the transaction with no B issued. Downstream cleanup is the system's responsibility.
- IDLE:
  - All readies and valids are 0.
  - If any slv_aw_valid_i bit is set, idx_q <= first set bit searching upward from ptr_q with wrap-around. State moves to XFER.
  - W-valid alone does not trigger a grant.
  - Grant is registered, so the granted AW appears downstream no earlier than the cycle after it is first seen (minimum latency 1 cycle).
- XFER:
  - mst_aw_valid_o = slv_aw_valid_i[idx_q] & ~aw_done_q. Address is muxed from slice idx_q. slv_aw_ready_o[idx_q] = mst_aw_ready_i & ~aw_done_q.
  - W is muxed the same way, gated by w_done_q.
  - AW and W proceed independently and may complete in the same cycle or in either order. Each done flag is set on its handshake.
  - When both handshakes have occurred (flag set, or handshake this cycle), state moves to RESP and both flags clear.
  - Non-granted masters see ready=0.
- RESP:
  - slv_b_valid_o[idx_q] = mst_b_valid_i. mst_b_ready_o = slv_b_ready_i[idx_q]. All slv_b_resp_o slices equal mst_b_resp_i.
  - On B handshake, state moves to IDLE and ptr_q <= idx_q+1, wrapping to 0 after NoMst-1.
  - B must not be accepted downstream before RESP. mst_b_ready_o=0 in the other states.
- Fairness: with all masters requesting continuously, grants cycle 0,1,...,NoMst-1,0. Worst-case wait is NoMst-1 transactions.
- Throughput: minimum 3 cycles per write (IDLE, XFER, RESP).
- Paths: valid-to-ready is combinational through the muxes. There is no combinational path from slave-side valids to slave-side readies outside idx_q.

Optional Feature:
- Macro: AXI_LITE_WR_ARB_GRANT_CNT_EN.
- When defined:
  - Adds output port grant_cnt_o, width NoMst*16.
  - Slice k increments on every AW handshake of master k and saturates at 16'hFFFF.
  - Reset clears all slices to 0.
- When undefined: the port and counters do not exist, and behaviour is otherwise identical.

Test Plan:
- Single write: master 2 sends AW addr 0xDEADBEEF and W data 0xDEADBEEF with strb 0xF. Downstream returns OKAY. Required: downstream sees that AW and W, and master 2 receives B resp 2'b00, with no B at any other master.
- All 4 masters request continuously, 8 writes. Required: grant order 0,1,2,3,0,1,2,3, confirmed by downstream addresses (0x1000+k).
- W before AW: master 1 asserts W 2 cycles before AW. Required: no W handshake before the grant, then both complete, and B is delivered to master 1.
- Backpressure: downstream ready low for 5 cycles on AW and B returns SLVERR. Required: master 0 receives slv_b_resp 2'b10, and no other master is granted in the meantime.
- Reset in RESP: assert rst_i for 1 cycle. Required: next cycle all valids and readies are 0, state is IDLE, and ptr_q=0.
- With AXI_LITE_WR_ARB_GRANT_CNT_EN defined, 3 writes by master 3. Required: grant_cnt_o slice 3 = 3 and the others = 0.

Source files
------------

// File: rtl/axi_lite_wr_arbiter.sv
// rtl/axi_lite_wr_arbiter.sv - round-robin AXI-Lite write-channel arbiter (optional macro AXI_LITE_WR_ARB_GRANT_CNT_EN)
module axi_lite_wr_arbiter #(
    parameter int NoMst     = 4,
    parameter int AddrWidth = 32,
    parameter int DataWidth = 32,
    parameter int IdxWidth  = $clog2(NoMst)
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
`ifdef AXI_LITE_WR_ARB_GRANT_CNT_EN
    output logic [NoMst*16-1:0]              grant_cnt_o,
`endif
    input  logic [NoMst-1:0]                 slv_aw_valid_i,
    input  logic [NoMst*AddrWidth-1:0]       slv_aw_addr_i,
    output logic [NoMst-1:0]                 slv_aw_ready_o,
    input  logic [NoMst-1:0]                 slv_w_valid_i,
    input  logic [NoMst*DataWidth-1:0]       slv_w_data_i,
    input  logic [NoMst*(DataWidth/8)-1:0]   slv_w_strb_i,
    output logic [NoMst-1:0]                 slv_w_ready_o,
    output logic [NoMst-1:0]                 slv_b_valid_o,
    output logic [NoMst*2-1:0]               slv_b_resp_o,
    input  logic [NoMst-1:0]                 slv_b_ready_i,
    output logic                             mst_aw_valid_o,
    output logic [AddrWidth-1:0]             mst_aw_addr_o,
    input  logic                             mst_aw_ready_i,
    output logic                             mst_w_valid_o,
    output logic [DataWidth-1:0]             mst_w_data_o,
    output logic [DataWidth/8-1:0]           mst_w_strb_o,
    input  logic                             mst_w_ready_i,
    input  logic                             mst_b_valid_i,
    input  logic [1:0]                       mst_b_resp_i,
    output logic                             mst_b_ready_o
);

    localparam int StrbWidth = DataWidth / 8;
    localparam logic [IdxWidth-1:0] IdxLast = IdxWidth'(NoMst - 1);
    localparam logic [IdxWidth-1:0] IdxOne  = IdxWidth'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              state_q;
    logic [IdxWidth-1:0] idx_q;
    logic [IdxWidth-1:0] ptr_q;
    logic                aw_done_q;
    logic                w_done_q;

    logic [IdxWidth-1:0] next_idx;
    logic [IdxWidth-1:0] cand;
    logic                found;
    logic                aw_hs;
    logic                w_hs;
    logic                b_hs;
    logic                aw_fin;
    logic                w_fin;

    // round-robin search: first requesting AW master at or above ptr_q, wrapping
    always_comb begin
        next_idx = ptr_q;
        cand     = ptr_q;
        found    = 1'b0;
        for (int i = 0; i < NoMst; i++) begin
            if (int'(ptr_q) + i >= NoMst) begin
                cand = IdxWidth'(int'(ptr_q) + i - NoMst);
            end else begin
                cand = IdxWidth'(int'(ptr_q) + i);
            end
            if (!found && slv_aw_valid_i[cand]) begin
                next_idx = cand;
                found    = 1'b1;
            end
        end
    end

    // channel muxing toward the granted master; everything quiet while in reset
    always_comb begin
        slv_aw_ready_o = '0;
        slv_w_ready_o  = '0;
        slv_b_valid_o  = '0;
        slv_b_resp_o   = {NoMst{mst_b_resp_i}};
        mst_aw_valid_o = 1'b0;
        mst_aw_addr_o  = slv_aw_addr_i[idx_q*AddrWidth +: AddrWidth];
        mst_w_valid_o  = 1'b0;
        mst_w_data_o   = slv_w_data_i[idx_q*DataWidth +: DataWidth];
        mst_w_strb_o   = slv_w_strb_i[idx_q*StrbWidth +: StrbWidth];
        mst_b_ready_o  = 1'b0;
        if (!rst_i) begin
            case (state_q)
                XFER: begin
                    mst_aw_valid_o        = slv_aw_valid_i[idx_q] & ~aw_done_q;
                    slv_aw_ready_o[idx_q] = mst_aw_ready_i & ~aw_done_q;
                    mst_w_valid_o         = slv_w_valid_i[idx_q] & ~w_done_q;
                    slv_w_ready_o[idx_q]  = mst_w_ready_i & ~w_done_q;
                end
                RESP: begin
                    slv_b_valid_o[idx_q] = mst_b_valid_i;
                    mst_b_ready_o        = slv_b_ready_i[idx_q];
                end
                default: ;
            endcase
        end
    end

    assign aw_hs  = mst_aw_valid_o & mst_aw_ready_i;
    assign w_hs   = mst_w_valid_o & mst_w_ready_i;
    assign b_hs   = mst_b_valid_i & mst_b_ready_o;
    assign aw_fin = aw_done_q | aw_hs;
    assign w_fin  = w_done_q | w_hs;

    // grant / transfer / response sequencing with round-robin pointer update
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            ptr_q     <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|slv_aw_valid_i) begin
                        idx_q   <= next_idx;
                        state_q <= XFER;
                    end
                end
                XFER: begin
                    if (aw_fin && w_fin) begin
                        state_q   <= RESP;
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                    end else begin
                        aw_done_q <= aw_fin;
                        w_done_q  <= w_fin;
                    end
                end
                RESP: begin
                    if (b_hs) begin
                        state_q <= IDLE;
                        ptr_q   <= (idx_q == IdxLast) ? '0 : idx_q + IdxOne;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef AXI_LITE_WR_ARB_GRANT_CNT_EN
    logic [NoMst*16-1:0] grant_cnt_q;

    // per-master saturating count of accepted AW beats
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            grant_cnt_q <= '0;
        end else if (aw_hs) begin
            for (int k = 0; k < NoMst; k++) begin
                if (idx_q == IdxWidth'(k) && grant_cnt_q[k*16 +: 16] != 16'hFFFF) begin
                    grant_cnt_q[k*16 +: 16] <= grant_cnt_q[k*16 +: 16] + 16'd1;
                end
            end
        end
    end

    assign grant_cnt_o = grant_cnt_q;
`endif

endmodule

// File: tb/tb_axi_lite_wr_arbiter.sv
// tb/tb_axi_lite_wr_arbiter.sv - directed self-checking bench for axi_lite_wr_arbiter
module tb_axi_lite_wr_arbiter;

    logic         clk;
    logic         rst;
    logic [3:0]   aw_valid;
    logic [127:0] aw_addr;
    logic [3:0]   aw_ready;
    logic [3:0]   w_valid;
    logic [127:0] w_data;
    logic [15:0]  w_strb;
    logic [3:0]   w_ready;
    logic [3:0]   b_valid;
    logic [7:0]   b_resp;
    logic [3:0]   b_ready;
    logic         m_aw_valid;
    logic [31:0]  m_aw_addr;
    logic         m_aw_ready;
    logic         m_w_valid;
    logic [31:0]  m_w_data;
    logic [3:0]   m_w_strb;
    logic         m_w_ready;
    logic         m_b_valid;
    logic [1:0]   m_b_resp;
    logic         m_b_ready;
`ifdef AXI_LITE_WR_ARB_GRANT_CNT_EN
    logic [63:0]  grant_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    axi_lite_wr_arbiter #(
        .NoMst(4), .AddrWidth(32), .DataWidth(32)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
`ifdef AXI_LITE_WR_ARB_GRANT_CNT_EN
        .grant_cnt_o    (grant_cnt),
`endif
        .slv_aw_valid_i (aw_valid),
        .slv_aw_addr_i  (aw_addr),
        .slv_aw_ready_o (aw_ready),
        .slv_w_valid_i  (w_valid),
        .slv_w_data_i   (w_data),
        .slv_w_strb_i   (w_strb),
        .slv_w_ready_o  (w_ready),
        .slv_b_valid_o  (b_valid),
        .slv_b_resp_o   (b_resp),
        .slv_b_ready_i  (b_ready),
        .mst_aw_valid_o (m_aw_valid),
        .mst_aw_addr_o  (m_aw_addr),
        .mst_aw_ready_i (m_aw_ready),
        .mst_w_valid_o  (m_w_valid),
        .mst_w_data_o   (m_w_data),
        .mst_w_strb_o   (m_w_strb),
        .mst_w_ready_i  (m_w_ready),
        .mst_b_valid_i  (m_b_valid),
        .mst_b_resp_i   (m_b_resp),
        .mst_b_ready_o  (m_b_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    function automatic logic [63:0] all_vr();
        return {40'd0, aw_ready, w_ready, b_valid, m_aw_valid, m_w_valid, m_b_ready};
    endfunction

    task automatic wait_aw(input string tag);
        int t = 0;
        while (m_aw_valid !== 1'b1 && t < 10) begin
            tick();
            mid();
            t++;
        end
        check(tag, {63'd0, m_aw_valid}, 64'd1);
    endtask

    initial begin
        rst = 1'b1; aw_valid = '0; aw_addr = '0; w_valid = '0; w_data = '0; w_strb = '0;
        b_ready = '0; m_aw_ready = 1'b0; m_w_ready = 1'b0; m_b_valid = 1'b0; m_b_resp = 2'b00;

        // reset state
        tick(); tick();
        mid();
        check("rst_during", all_vr(), 64'd0);
        tick(); rst = 1'b0;
        mid();
        check("rst_after", all_vr(), 64'd0);

        // single write by master 2
        tick();
        aw_valid = 4'b0100; aw_addr[64 +: 32] = 32'hDEADBEEF;
        w_valid = 4'b0100; w_data[64 +: 32] = 32'hDEADBEEF; w_strb[8 +: 4] = 4'hF;
        m_aw_ready = 1'b1; m_w_ready = 1'b1; b_ready = 4'b0100;
        mid();
        check("t1_latency", {63'd0, m_aw_valid}, 64'd0);
        tick();
        mid();
        check("t1_aw_valid", {63'd0, m_aw_valid}, 64'd1);
        check("t1_aw_addr", {32'd0, m_aw_addr}, 64'hDEADBEEF);
        check("t1_w", {28'd0, m_w_strb, m_w_data}, {28'd0, 4'hF, 32'hDEADBEEF});
        check("t1_readies", {56'd0, aw_ready, w_ready}, {56'd0, 4'b0100, 4'b0100});
        tick();
        aw_valid = '0; w_valid = '0; m_b_valid = 1'b1; m_b_resp = 2'b00;
        mid();
        check("t1_b_valid", {60'd0, b_valid}, 64'd4);
        check("t1_b_resp", {62'd0, b_resp[5:4]}, 64'd0);
        check("t1_b_ready", {63'd0, m_b_ready}, 64'd1);
        tick();
        m_b_valid = 1'b0;
        mid();
        check("t1_b_done", {60'd0, b_valid}, 64'd0);

        // round-robin with all masters requesting continuously
        tick(); rst = 1'b1;
        tick(); rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            aw_addr[k*32 +: 32] = 32'h1000 + k;
            w_data[k*32 +: 32] = 32'h2000 + k;
        end
        w_strb = 16'hFFFF; aw_valid = 4'hF; w_valid = 4'hF; b_ready = 4'hF;
        m_b_valid = 1'b1; m_b_resp = 2'b00;
        for (int n = 0; n < 8; n++) begin
            mid();
            wait_aw($sformatf("t2_wait%0d", n));
            check($sformatf("t2_addr%0d", n), {32'd0, m_aw_addr}, 64'h1000 + (n % 4));
            check($sformatf("t2_b_early%0d", n), {59'd0, b_valid, m_b_ready}, 64'd0);
            tick();
            if (n == 7) begin
                aw_valid = '0; w_valid = '0;
            end
        end
        mid();
        check("t2_last_b", {60'd0, b_valid}, 64'd8);
        tick();
        m_b_valid = 1'b0;

        // W presented two cycles before AW by master 1
        w_valid = 4'b0010; w_data[32 +: 32] = 32'hCAFE0001;
        mid();
        check("t3_w_early0", {59'd0, w_ready, m_w_valid}, 64'd0);
        tick();
        mid();
        check("t3_w_early1", {59'd0, w_ready, m_w_valid}, 64'd0);
        tick();
        aw_valid = 4'b0010; aw_addr[32 +: 32] = 32'h3000;
        mid();
        check("t3_idle", {63'd0, m_aw_valid}, 64'd0);
        tick();
        mid();
        check("t3_readies", {56'd0, aw_ready, w_ready}, {56'd0, 4'b0010, 4'b0010});
        check("t3_w_data", {32'd0, m_w_data}, 64'hCAFE0001);
        tick();
        aw_valid = '0; w_valid = '0; m_b_valid = 1'b1;
        mid();
        check("t3_b_valid", {60'd0, b_valid}, 64'd2);
        tick();
        m_b_valid = 1'b0;

        // AW backpressure on master 0 while the others request
        aw_valid = 4'b0001; aw_addr[0 +: 32] = 32'hA000; w_valid = 4'b0001;
        m_aw_ready = 1'b0; m_w_ready = 1'b1;
        mid();
        tick();
        aw_valid = 4'hF;
        mid();
        check("t4_w_first", {60'd0, w_ready}, 64'd1);
        check("t4_aw_blocked0", {60'd0, aw_ready}, 64'd0);
        tick();
        for (int i = 1; i < 5; i++) begin
            mid();
            check($sformatf("t4_hold%0d", i), {28'd0, aw_ready, m_aw_addr},
                  {28'd0, 4'b0000, 32'hA000});
            check($sformatf("t4_w_done%0d", i), {59'd0, w_ready, m_w_valid}, 64'd0);
            tick();
        end
        m_aw_ready = 1'b1;
        mid();
        check("t4_aw_go", {60'd0, aw_ready}, 64'd1);
        tick();
        aw_valid = '0; w_valid = '0; m_b_valid = 1'b1; m_b_resp = 2'b10;
        mid();
        check("t4_b", {58'd0, b_resp[1:0], b_valid}, {58'd0, 2'b10, 4'b0001});
        tick();
        m_b_valid = 1'b0; m_b_resp = 2'b00;

        // reset while in RESP
        aw_valid = 4'b1000; aw_addr[96 +: 32] = 32'hB000; w_valid = 4'b1000; b_ready = '0;
        mid();
        tick();
        mid();
        tick();
        aw_valid = '0; w_valid = '0; m_b_valid = 1'b1;
        mid();
        check("t5_resp", {59'd0, b_valid, m_b_ready}, {59'd0, 4'b1000, 1'b0});
        tick();
        rst = 1'b1; aw_valid = 4'hF; w_valid = 4'hF;
        mid();
        check("t5_during", all_vr(), 64'd0);
        tick();
        rst = 1'b0;
        mid();
        check("t5_after", all_vr(), 64'd0);
        tick();
        mid();
        check("t5_ptr0", {31'd0, m_aw_valid, m_aw_addr}, {31'd0, 1'b1, 32'hA000});
        tick();
        aw_valid = '0; w_valid = '0; b_ready = 4'hF;
        mid();
        check("t5_b_m0", {60'd0, b_valid}, 64'd1);
        tick();
        m_b_valid = 1'b0;

`ifdef AXI_LITE_WR_ARB_GRANT_CNT_EN
        // three writes by master 3 after a fresh reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mid();
        check("t6_cnt_rst", grant_cnt, 64'd0);
        for (int n = 0; n < 3; n++) begin
            tick();
            aw_valid = 4'b1000; w_valid = 4'b1000; m_b_valid = 1'b1;
            mid();
            wait_aw($sformatf("t6_wait%0d", n));
            tick();
            aw_valid = '0; w_valid = '0;
            mid();
            tick();
            m_b_valid = 1'b0;
            mid();
        end
        check("t6_cnt", grant_cnt, {16'd3, 48'd0});
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
